board_line_clear: RTL and testbench
===================================

Name: board_line_clear

Overview:
- Sequential row-clear engine directly upstream of the grid renderer.
- On a start pulse it takes a locked 12x20 board snapshot and scans it bottom-to-top for full rows.
- Each full row is removed and everything above it shifts down. The compacted board is presented on board_out, the 240-bit grid bus the renderer consumes.
- Also reports the lines cleared per operation and a running total.

Parameters:
- COLS, 12, columns per row (bits per row slice)
- ROWS, 20, rows in the board; grid width = COLS*ROWS

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to process board_in; sampled only when busy=0
- board_in  input  240  board snapshot; row r occupies bits [(ROWS-1-r)*COLS +: COLS], row 0 = top (bits 239:228), row 19 = bottom (bits 11:0), column c = bit c of row slice
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when board_out/lines_cleared are updated
- board_out  output  240  compacted board, same layout as board_in, held between operations
- lines_cleared  output  5  full rows removed by the last operation (0..20)
- total_lines  output  16  running sum of lines_cleared, saturates at 16'hFFFF
- score  output  16  see Optional Feature

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, board_out=0, lines_cleared=0, total_lines=0, score=0, work register=0, row pointer=ROWS-1. Reset mid-operation aborts the operation immediately and discards all progress.
- States: IDLE, SCAN, SHIFT.
- IDLE, start=1 at edge:
  - work<=board_in, ptr<=ROWS-1, count<=0, busy<=1, state<=SCAN.
  - board_in is not sampled again during the operation.
- SCAN (one row per cycle):
  - Row work[ptr] all ones: state<=SHIFT, ptr unchanged.
  - Otherwise, ptr==0: board_out<=work, lines_cleared<=count, total_lines<=sat(total_lines+count), done<=1, busy<=0, state<=IDLE.
  - Otherwise: ptr<=ptr-1.
- SHIFT (single cycle):
  - work row r <= row r-1 for 1<=r<=ptr; row 0 <= 0; rows below ptr unchanged.
  - count<=count+1, state<=SCAN.
  - The same ptr is re-examined next, so stacked full rows are each cleared.
- Latency: done asserts exactly ROWS+2k rising edges after the edge that accepted start, where k = rows cleared. Range: 20 for no clears, 60 for a completely full board.
- done is high for exactly one cycle; all other outputs are registered and hold until the next done or reset.
- start while busy=1 is ignored (no queuing).
- start in the cycle done=1 is accepted (state is IDLE) and begins a new operation.
- Empty board: 20 scan cycles, board_out=0, lines_cleared=0.
- Row 0 full: shifted to zero and rescanned; no underflow of ptr.
- total_lines saturation: sum computed 17-bit and clamped to 16'hFFFF; it never wraps.

Optional Feature:
- Macro: LINE_CLEAR_SCORE_EN.
- Defined: on each done, score <= sat16(score + points(lines_cleared)), with points 0/40/100/300/1200 for k=0/1/2/3/4 and 1200 for k>4. Reset clears score.
- Undefined: score port present but tied to 16'h0000; no scoring logic synthesised.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then board_in=0, start pulse -> done exactly 20 cycles later, board_out=0, lines_cleared=0, busy high for those 20 cycles.
- Bottom row full (bits 11:0=12'hFFF), row 18 = 12'h001, rest 0 -> done after 22 cycles, board_out[11:0]=12'h001, all other bits 0, lines_cleared=1, total_lines=1.
- Rows 16..19 full, row 15 = 12'h0F0 -> done after 28 cycles, board_out bottom row 12'h0F0, rest 0, lines_cleared=4; with LINE_CLEAR_SCORE_EN score=1200, without score=0.
- All 240 bits set -> done after 60 cycles, board_out=0, lines_cleared=20; a second start pulse issued while busy has no effect.
- Start a full-board operation, assert rst at cycle 10 -> busy=0, done=0, board_out=0, total_lines=0 immediately; a fresh start after rst release behaves as a first run.
- Preload total_lines near saturation (repeated full-board ops) -> total_lines clamps at 16'hFFFF and never wraps.

Source files
------------

// File: rtl/board_line_clear.sv
// rtl/board_line_clear.sv - sequential full-row clear engine for a COLS x ROWS board
// Optional scoring is built only when LINE_CLEAR_SCORE_EN is defined.
module board_line_clear #(
  parameter int COLS = 12,
  parameter int ROWS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [COLS*ROWS-1:0] board_in,
  output logic                 busy,
  output logic                 done,
  output logic [COLS*ROWS-1:0] board_out,
  output logic [4:0]           lines_cleared,
  output logic [15:0]          total_lines,
  output logic [15:0]          score
);

  localparam int W  = COLS * ROWS;
  localparam int PW = $clog2(ROWS);
  localparam logic [PW-1:0] PTR_BOT = PW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  work_q, work_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [4:0]    count_q, count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  board_out_q, board_out_d;
  logic [4:0]    lines_q, lines_d;
  logic [15:0]   total_q, total_d;

  logic [COLS-1:0] row_sel;
  logic            row_full;
  logic            finish;
  logic [W-1:0]    shifted;
  logic [16:0]     total_sum;

  // Row ptr lives at bit offset (ROWS-1-ptr)*COLS: row 0 is the top, highest slice.
  always_comb begin
    row_sel = work_q[(ROWS-1-int'(ptr_q))*COLS +: COLS];
  end

  assign row_full  = &row_sel;
  assign finish    = (state_q == SCAN) && !row_full && (ptr_q == '0);
  assign total_sum = {1'b0, total_q} + {12'b0, count_q};

  // Drop every row at or above ptr by one; the top row becomes empty.
  always_comb begin
    shifted = work_q;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) begin
        shifted[(ROWS-1)*COLS +: COLS] = '0;
      end else if (r <= int'(ptr_q)) begin
        shifted[(ROWS-1-r)*COLS +: COLS] = work_q[(ROWS-r)*COLS +: COLS];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    board_out_d = board_out_q;
    lines_d     = lines_q;
    total_d     = total_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = board_in;
          ptr_d   = PTR_BOT;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (row_full) begin
          state_d = SHIFT;
        end else if (ptr_q == '0) begin
          board_out_d = work_q;
          lines_d     = count_q;
          total_d     = total_sum[16] ? 16'hFFFF : total_sum[15:0];
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          ptr_d = ptr_q - PW'(1);
        end
      end
      SHIFT: begin
        work_d  = shifted;
        count_d = count_q + 5'd1;
        state_d = SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      ptr_q       <= PTR_BOT;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      board_out_q <= '0;
      lines_q     <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      board_out_q <= board_out_d;
      lines_q     <= lines_d;
      total_q     <= total_d;
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [15:0] pts;
  logic [16:0] score_sum;

  always_comb begin
    case (count_q)
      5'd0:    pts = 16'd0;
      5'd1:    pts = 16'd40;
      5'd2:    pts = 16'd100;
      5'd3:    pts = 16'd300;
      default: pts = 16'd1200;
    endcase
  end

  assign score_sum = {1'b0, score_q} + {1'b0, pts};

  always_comb begin
    score_d = score_q;
    if (finish) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = 16'h0000;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign board_out     = board_out_q;
  assign lines_cleared = lines_q;
  assign total_lines   = total_q;

endmodule

// File: tb/tb_board_line_clear.sv
// tb/tb_board_line_clear.sv - scoreboard bench for board_line_clear
// Directed and random boards against a row-list reference model.
module tb_board_line_clear;
  localparam int COLS = 12;
  localparam int ROWS = 20;
  localparam int W    = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  board_in = '0;
  logic          busy, done;
  logic [W-1:0]  board_out;
  logic [4:0]    lines_cleared;
  logic [15:0]   total_lines, score;

  board_line_clear #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in),
    .busy(busy), .done(done), .board_out(board_out),
    .lines_cleared(lines_cleared), .total_lines(total_lines), .score(score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] board;
    int           lines;
    int           total;
    int           score;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   m_total = 0;
  int   m_score = 0;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Keep non-full rows in bottom-to-top order and stack them at the bottom.
  function automatic void model(input logic [W-1:0] b, output logic [W-1:0] o, output int k);
    logic [COLS-1:0] row;
    int dst;
    dst = ROWS - 1;
    k = 0;
    o = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = b[(ROWS-1-r)*COLS +: COLS];
      if (row == {COLS{1'b1}}) begin
        k++;
      end else begin
        o[(ROWS-1-dst)*COLS +: COLS] = row;
        dst--;
      end
    end
  endfunction

  function automatic int points(input int k);
    case (k)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e_m = sb.pop_front();
        chk("board_out", board_out, e_m.board);
        chk("lines_cleared", W'(lines_cleared), W'(e_m.lines));
        chk("total_lines", W'(total_lines), W'(e_m.total));
        chk("score", W'(score), W'(e_m.score));
        chk("done_cycle", W'(cyc), W'(e_m.due));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] b, input bit poke_busy, input bit b2b);
    logic [W-1:0] o;
    int k, lat, bc;
    model(b, o, k);
    m_total = (m_total + k > 65535) ? 65535 : m_total + k;
`ifdef LINE_CLEAR_SCORE_EN
    m_score = (m_score + points(k) > 65535) ? 65535 : m_score + points(k);
`else
    m_score = 0;
`endif
    if (!b2b) @(negedge clk);
    board_in = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    board_in = ~b;
    lat = ROWS + 2 * k;
    sb.push_back('{o, k, m_total, m_score, cyc + lat});
    bc = 0;
    repeat (200) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      start = poke_busy && (bc == 5);
    end
    start = 1'b0;
    chk("busy_cycles", W'(bc), W'(lat));
  endtask

  function automatic logic [W-1:0] rand_board();
    logic [W-1:0] b;
    b = '0;
    for (int r = 0; r < ROWS; r++) begin
      case ($urandom_range(0, 2))
        0: b[(ROWS-1-r)*COLS +: COLS] = '1;
        1: b[(ROWS-1-r)*COLS +: COLS] = '0;
        default: b[(ROWS-1-r)*COLS +: COLS] = COLS'($urandom);
      endcase
    end
    return b;
  endfunction

  logic [W-1:0] bd;
  logic [W-1:0] full_b;

  initial begin
    full_b = '1;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_board_out", board_out, '0);
    chk("rst_total", W'(total_lines), W'(0));
    chk("rst_score", W'(score), W'(0));
    rst = 1'b0;

    run_op('0, 1'b0, 1'b0);

    bd = '0;
    bd[11:0]  = 12'hFFF;
    bd[23:12] = 12'h001;
    run_op(bd, 1'b0, 1'b0);

    bd = '0;
    bd[47:0]  = '1;
    bd[59:48] = 12'h0F0;
    run_op(bd, 1'b0, 1'b0);

    run_op(full_b, 1'b1, 1'b0);

    // Abort a full-board run mid-operation.
    @(negedge clk);
    board_in = full_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_board_out", board_out, '0);
    chk("abort_total", W'(total_lines), W'(0));
    chk("abort_lines", W'(lines_cleared), W'(0));
    sb.delete();
    m_total = 0;
    m_score = 0;
    @(negedge clk);
    rst = 1'b0;
    bd = '0;
    bd[11:0] = 12'hFFF;
    run_op(bd, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op(rand_board(), 1'b0, (i % 2) == 1);
    end

    // Preload the running total close to the top, then overflow it.
    @(negedge clk);
    force dut.total_q = 16'hFFD0;
    @(negedge clk);
    release dut.total_q;
    m_total = 16'hFFD0;
    repeat (4) run_op(full_b, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", W'(sb.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
